// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_HEX[nibble];

endmodule

// File: rtl/outport_seg7_scanner.sv
// Scans the 32-bit output port onto an 8-digit common-anode display,
// capturing a new value only at frame wrap so a frame never tears.
module outport_seg7_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] outport_data,
    input  logic        blank_lz,
    output logic [7:0]  digit_en_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (DIGITS != 8) begin : g_digits_chk
        $error("outport_seg7_scanner: DIGITS must be 8");
    end

    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_div_chk
        $error("outport_seg7_scanner: SCAN_DIV out of range");
    end

    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [31:0]   shadow;
    logic          load_pend;

    logic          tc;
    logic          wrap;
    logic [4:0]    bit_pos;
    logic [3:0]    nibble;
    logic [31:0]   upper;
    logic          lz_blank;
    logic          stale;
    logic [6:0]    seg_dec;

    assign tc       = (div_cnt == CW'(SCAN_DIV - 1));
    assign wrap     = tc && (idx == 3'd7);
    assign bit_pos  = {idx, 2'b00};
    assign nibble   = shadow[bit_pos +: 4];
    assign upper    = shadow >> bit_pos;
    assign lz_blank = blank_lz && (idx != 3'd0) && (upper == 32'd0);
    assign stale    = (outport_data != shadow);

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg_n  (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= 3'd0;
            shadow     <= 32'd0;
            load_pend  <= 1'b1;
            digit_en_n <= AN_OFF;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + 1'b1;
            if (tc) begin
                idx <= idx + 3'd1;
            end
            // Pin registers use pre-capture shadow, keeping anode and segments coherent.
            if (load_pend || wrap) begin
                shadow    <= outport_data;
                load_pend <= 1'b0;
            end
            frame_done <= wrap;
            if (div_cnt == '0) begin
                digit_en_n <= AN_OFF;
                seg_n      <= SEG_BLANK;
                dp_n       <= 1'b1;
            end else begin
                digit_en_n <= ~(8'd1 << idx);
                seg_n      <= lz_blank ? SEG_BLANK : seg_dec;
                dp_n       <= !((idx == 3'd0) && stale);
            end
        end
    end

endmodule

// File: tb/tb_outport_seg7_scanner.sv
// Randomised self-checking bench for outport_seg7_scanner (SCAN_DIV = 4).
// A positional model predicts every pin after each clock edge.
module tb_outport_seg7_scanner;

    localparam int SD = 4;
    localparam int FRAME = SD * 8;

    logic        clk;
    logic        rst;
    logic [31:0] outport_data;
    logic        blank_lz;
    logic [7:0]  digit_en_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int n_chk;
    int n_fail;

    logic [6:0] hex_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: p = clock edges since reset release; slot and digit follow from p.
    int          p;
    logic [31:0] m_shadow;
    logic [7:0]  e_en;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    outport_seg7_scanner #(.SCAN_DIV(SD), .DIGITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .outport_data (outport_data),
        .blank_lz     (blank_lz),
        .digit_en_n   (digit_en_n),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        int k;
        logic [31:0] up;
        @(posedge clk);
        e_en  = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
        if (rst) begin
            p = 0;
            m_shadow = 32'd0;
        end else begin
            k  = (p / SD) % 8;
            up = m_shadow / (32'd1 << (4 * k));
            if (p % SD != 0) begin
                e_en  = ~(8'd1 << k);
                e_seg = hex_ref[up % 16];
                if (blank_lz && k > 0 && up == 0) e_seg = 7'h7F;
                e_dp  = !(k == 0 && outport_data != m_shadow);
            end
            e_fd = (p % FRAME == FRAME - 1);
            if (p == 0 || p % FRAME == FRAME - 1) m_shadow = outport_data;
            p++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        outport_data = 32'h12345678;
        blank_lz = 1'b0;
        p = 0;
        m_shadow = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (digit_en_n !== 8'hFF) begin
            n_fail++; $display("FAIL reset_en got %h want ff", digit_en_n);
        end
        n_chk++;
        if (seg_n !== 7'h7F) begin
            n_fail++; $display("FAIL reset_seg got %b want 1111111", seg_n);
        end
        n_chk++;
        if (dp_n !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_dp_fd got %b%b want 10", dp_n, frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            @(negedge clk);
            n_chk++;
            if ({digit_en_n, seg_n, dp_n, frame_done} !== {e_en, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL first_frame p=%0d got %h %b %b %b want %h %b %b %b",
                         p, digit_en_n, seg_n, dp_n, frame_done, e_en, e_seg, e_dp, e_fd);
            end
            if (p == 2) begin
                n_chk++;
                if (digit_en_n !== 8'hFE || seg_n !== 7'b0000000) begin
                    n_fail++; $display("FAIL idx0_digit got %h %b want fe 0000000", digit_en_n, seg_n);
                end
            end
            if (p == 30) begin
                n_chk++;
                if (digit_en_n !== 8'h7F || seg_n !== 7'b1111001) begin
                    n_fail++; $display("FAIL idx7_digit got %h %b want 7f 1111001", digit_en_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        int dp_low;
        dp_low = 0;
        while (p % FRAME != 13) begin
            tick(); @(negedge clk);
        end
        outport_data = 32'hDEADBEEF;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            @(negedge clk);
            n_chk++;
            if ({digit_en_n, seg_n, dp_n, frame_done} !== {e_en, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL tear_free p=%0d got %h %b %b %b want %h %b %b %b",
                         p, digit_en_n, seg_n, dp_n, frame_done, e_en, e_seg, e_dp, e_fd);
            end
            if (!dp_n) dp_low++;
            if (i == FRAME + 19) outport_data = 32'hCAFEF00D;
        end
        n_chk++;
        if (dp_low != SD - 1) begin
            n_fail++; $display("FAIL stale_dp got %0d low cycles want %0d", dp_low, SD - 1);
        end
    endtask

    task automatic test_blank_gap();
        int fd_cnt;
        fd_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            @(negedge clk);
            if ((p - 1) % SD == 0) begin
                n_chk++;
                if (digit_en_n !== 8'hFF || seg_n !== 7'h7F) begin
                    n_fail++; $display("FAIL blank_gap p=%0d got %h %b want ff 1111111", p, digit_en_n, seg_n);
                end
            end
            if (frame_done) fd_cnt++;
        end
        n_chk++;
        if (fd_cnt != 3) begin
            n_fail++; $display("FAIL frame_done_rate got %0d want 3", fd_cnt);
        end
    endtask

    task automatic test_leading_zero();
        blank_lz = 1'b1;
        outport_data = 32'h000000A0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            @(negedge clk);
            n_chk++;
            if ({digit_en_n, seg_n, dp_n, frame_done} !== {e_en, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL leading_zero p=%0d got %h %b %b %b want %h %b %b %b",
                         p, digit_en_n, seg_n, dp_n, frame_done, e_en, e_seg, e_dp, e_fd);
            end
            if (i == 2 * FRAME) outport_data = 32'd0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick();
            @(negedge clk);
            n_chk++;
            if ({digit_en_n, seg_n, dp_n, frame_done} !== {e_en, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL random p=%0d got %h %b %b %b want %h %b %b %b",
                         p, digit_en_n, seg_n, dp_n, frame_done, e_en, e_seg, e_dp, e_fd);
            end
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0: outport_data = $urandom;
                    1: outport_data = $urandom >> (4 * $urandom_range(1, 7));
                    default: outport_data = 32'd0;
                endcase
            end
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
        end
    endtask

    task automatic test_async_reset();
        while (p % FRAME != 22) begin
            tick(); @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (digit_en_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got %h %b %b %b want ff 1111111 1 0",
                               digit_en_n, seg_n, dp_n, frame_done);
        end
        p = 0;
        m_shadow = 32'd0;
        outport_data = 32'h9ABCDEF0;
        blank_lz = 1'b0;
        repeat (2) begin
            tick(); @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            @(negedge clk);
            n_chk++;
            if ({digit_en_n, seg_n, dp_n, frame_done} !== {e_en, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL post_reset p=%0d got %h %b %b %b want %h %b %b %b",
                         p, digit_en_n, seg_n, dp_n, frame_done, e_en, e_seg, e_dp, e_fd);
            end
            if (p == 2) begin
                n_chk++;
                if (seg_n !== 7'b1000000 || dp_n !== 1'b1) begin
                    n_fail++; $display("FAIL recapture got %b %b want 1000000 1", seg_n, dp_n);
                end
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_first_frame();
        test_tear_free();
        test_blank_gap();
        test_leading_zero();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
